// File: rtl/q_route_req_arbiter.sv
// rtl/q_route_req_arbiter.sv - round-robin arbiter sharing one Q-learning route engine between mesh nodes
module q_route_req_arbiter #(
    parameter int N_REQ   = 9,
    parameter int ID_W    = 4,
    parameter int INFO_W  = 10,
    parameter int ROUTE_W = 30,
    parameter int TIMEOUT = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*INFO_W-1:0]   i_req_info,
    input  logic                      i_eng_ready,
    output logic                      o_eng_req,
    output logic [INFO_W-1:0]         o_eng_sor_des,
    input  logic                      i_eng_done,
    input  logic [ROUTE_W-1:0]        i_eng_route,
    output logic                      o_resp_valid,
    output logic [N_REQ-1:0]          o_resp_onehot,
    output logic [ID_W-1:0]           o_resp_id,
    output logic [ROUTE_W-1:0]        o_resp_route,
    output logic                      o_resp_err,
    output logic                      o_busy
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ID_W:0]    N_REQ_W  = (ID_W+1)'(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               r_state;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [N_REQ-1:0]     r_mask;
    logic [TMR_W-1:0]     r_timer;
    logic [ID_W-1:0]      r_win_id;
    logic [INFO_W-1:0]    r_info;
    logic                 r_eng_req;
    logic                 r_resp_valid;
    logic [N_REQ-1:0]     r_resp_onehot;
    logic [ID_W-1:0]      r_resp_id;
    logic [ROUTE_W-1:0]   r_resp_route;
    logic                 r_resp_err;

    state_t               w_state_nxt;
    logic [ID_W-1:0]      w_rr_ptr_nxt;
    logic [N_REQ-1:0]     w_mask_nxt;
    logic [TMR_W-1:0]     w_timer_nxt;
    logic [ID_W-1:0]      w_win_id_nxt;
    logic [INFO_W-1:0]    w_info_nxt;
    logic                 w_eng_req_nxt;
    logic                 w_resp_valid_nxt;
    logic [N_REQ-1:0]     w_resp_onehot_nxt;
    logic [ID_W-1:0]      w_resp_id_nxt;
    logic [ROUTE_W-1:0]   w_resp_route_nxt;
    logic                 w_resp_err_nxt;

    logic [N_REQ-1:0]     w_eligible;
    logic [2*N_REQ-1:0]   w_dbl;
    logic                 w_found;
    logic [ID_W-1:0]      w_off;
    logic [ID_W:0]        w_sum;
    logic [ID_W-1:0]      w_winner;
    logic [INFO_W-1:0]    w_win_info;
    logic [N_REQ-1:0]     w_win_onehot;

    // The previous winner is hidden for one IDLE cycle so its stale request is not re-granted.
    assign w_eligible   = i_req_valid & ~r_mask;
    // Rotating the doubled vector puts rr_ptr at bit 0, so the first set bit is the round-robin winner.
    assign w_dbl        = {w_eligible, w_eligible} >> r_rr_ptr;
    assign w_sum        = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_winner     = (w_sum >= N_REQ_W) ? ID_W'(w_sum - N_REQ_W) : w_sum[ID_W-1:0];
    assign w_win_onehot = N_REQ'(1) << r_win_id;

    // Find the offset of the first eligible requester at or after rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && w_dbl[i]) begin
                w_found = 1'b1;
                w_off   = ID_W'(i);
            end
        end
    end

    // Select the src/dest info of the candidate winner.
    always_comb begin
        w_win_info = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_win_info = i_req_info[i*INFO_W +: INFO_W];
            end
        end
    end

    // Next-state and next-output logic; every output is a register so strobes are glitch free.
    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_mask_nxt        = r_mask;
        w_timer_nxt       = r_timer;
        w_win_id_nxt      = r_win_id;
        w_info_nxt        = r_info;
        w_eng_req_nxt     = 1'b0;
        w_resp_valid_nxt  = 1'b0;
        w_resp_onehot_nxt = '0;
        w_resp_id_nxt     = r_resp_id;
        w_resp_route_nxt  = r_resp_route;
        w_resp_err_nxt    = r_resp_err;
        case (r_state)
            S_IDLE: begin
                w_mask_nxt = '0;
                if (w_found && i_eng_ready) begin
                    w_win_id_nxt  = w_winner;
                    w_info_nxt    = w_win_info;
                    w_eng_req_nxt = 1'b1;
                    w_state_nxt   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_rr_ptr_nxt = (r_win_id == ID_W'(N_REQ - 1)) ? '0 : r_win_id + ID_W'(1);
                w_timer_nxt  = '0;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + TMR_W'(1);
                if (i_eng_done) begin
                    w_resp_route_nxt  = i_eng_route;
                    w_resp_err_nxt    = 1'b0;
                    w_resp_valid_nxt  = 1'b1;
                    w_resp_onehot_nxt = w_win_onehot;
                    w_resp_id_nxt     = r_win_id;
                    w_state_nxt       = S_RESP;
                end else if (r_timer == TMR_LAST) begin
                    w_resp_route_nxt  = '0;
                    w_resp_err_nxt    = 1'b1;
                    w_resp_valid_nxt  = 1'b1;
                    w_resp_onehot_nxt = w_win_onehot;
                    w_resp_id_nxt     = r_win_id;
                    w_state_nxt       = S_RESP;
                end
            end
            S_RESP: begin
                w_mask_nxt  = r_resp_onehot;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction without a response.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_mask        <= '0;
            r_timer       <= '0;
            r_win_id      <= '0;
            r_info        <= '0;
            r_eng_req     <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_onehot <= '0;
            r_resp_id     <= '0;
            r_resp_route  <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_mask        <= w_mask_nxt;
            r_timer       <= w_timer_nxt;
            r_win_id      <= w_win_id_nxt;
            r_info        <= w_info_nxt;
            r_eng_req     <= w_eng_req_nxt;
            r_resp_valid  <= w_resp_valid_nxt;
            r_resp_onehot <= w_resp_onehot_nxt;
            r_resp_id     <= w_resp_id_nxt;
            r_resp_route  <= w_resp_route_nxt;
            r_resp_err    <= w_resp_err_nxt;
        end
    end

    assign o_eng_req     = r_eng_req;
    assign o_eng_sor_des = r_info;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_onehot = r_resp_onehot;
    assign o_resp_id     = r_resp_id;
    assign o_resp_route  = r_resp_route;
    assign o_resp_err    = r_resp_err;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_q_route_req_arbiter.sv
// tb/tb_q_route_req_arbiter.sv - directed table-driven bench for q_route_req_arbiter
module tb_q_route_req_arbiter;

    localparam int N_REQ   = 9;
    localparam int ID_W    = 4;
    localparam int INFO_W  = 10;
    localparam int ROUTE_W = 30;
    localparam int TIMEOUT = 16;
    localparam int NVEC    = 21;

    logic                    clk;
    logic                    reset;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*INFO_W-1:0] req_info;
    logic                    eng_ready;
    logic                    eng_req;
    logic [INFO_W-1:0]       eng_sor_des;
    logic                    eng_done;
    logic [ROUTE_W-1:0]      eng_route;
    logic                    resp_valid;
    logic [N_REQ-1:0]        resp_onehot;
    logic [ID_W-1:0]         resp_id;
    logic [ROUTE_W-1:0]      resp_route;
    logic                    resp_err;
    logic                    busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N_REQ-1:0]   rv;
        int                 k;
        int                 rd;
        bit                 drop;
        logic [ROUTE_W-1:0] route;
        int                 exp_id;
        bit                 exp_err;
        int                 lat;
    } vec_t;

    vec_t              vecs[NVEC];
    logic [INFO_W-1:0] info_of[N_REQ];

    q_route_req_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .INFO_W(INFO_W), .ROUTE_W(ROUTE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_req_valid   (req_valid),
        .i_req_info    (req_info),
        .i_eng_ready   (eng_ready),
        .o_eng_req     (eng_req),
        .o_eng_sor_des (eng_sor_des),
        .i_eng_done    (eng_done),
        .i_eng_route   (eng_route),
        .o_resp_valid  (resp_valid),
        .o_resp_onehot (resp_onehot),
        .o_resp_id     (resp_id),
        .o_resp_route  (resp_route),
        .o_resp_err    (resp_err),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [N_REQ-1:0] rv, input int k, input int rd, input bit drop,
                                input logic [ROUTE_W-1:0] route, input int id, input bit err, input int lat);
        vec_t v;
        v.rv = rv; v.k = k; v.rd = rd; v.drop = drop; v.route = route;
        v.exp_id = id; v.exp_err = err; v.lat = lat;
        return v;
    endfunction

    // k = engine done delay after eng_req (0 = never), rd = cycles with eng_ready low, lat = req->resp cycles
    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int e;
        int r;
        int np;
        int exp_e;
        logic [N_REQ-1:0] oh;
        @(negedge clk);
        chk($sformatf("v%0d_idle_busy", idx), busy, 0);
        chk($sformatf("v%0d_resp_one_cycle", idx), resp_valid, 0);
        cyc = 0; e = -1; r = -1; np = 0;
        req_valid = v.rv;
        eng_route = v.route;
        while (r < 0 && cyc < 100) begin
            if (eng_req) begin
                np++;
                if (e < 0) begin
                    e = cyc;
                    chk($sformatf("v%0d_sor_des", idx), eng_sor_des, info_of[v.exp_id]);
                end
            end
            if (resp_valid) begin
                r = cyc;
                eng_done = 1'b0;
            end else begin
                eng_ready = (cyc >= v.rd);
                eng_done  = (e >= 0 && v.k > 0 && cyc == e + v.k);
                if (v.drop && e >= 0) req_valid = '0;
                @(negedge clk);
                cyc++;
            end
        end
        chk($sformatf("v%0d_resp_seen", idx), r >= 0, 1);
        if (r >= 0) begin
            exp_e = (v.k == 0) ? v.lat - TIMEOUT - 1 : v.lat - v.k - 1;
            oh = '0;
            oh[v.exp_id] = 1'b1;
            chk($sformatf("v%0d_eng_req_cycle", idx), e, exp_e);
            chk($sformatf("v%0d_eng_req_pulses", idx), np, 1);
            chk($sformatf("v%0d_latency", idx), r, v.lat);
            chk($sformatf("v%0d_resp_id", idx), resp_id, v.exp_id);
            chk($sformatf("v%0d_resp_onehot", idx), resp_onehot, oh);
            chk($sformatf("v%0d_resp_route", idx), resp_route, v.exp_err ? '0 : v.route);
            chk($sformatf("v%0d_resp_err", idx), resp_err, v.exp_err);
            chk($sformatf("v%0d_busy_resp", idx), busy, 1);
        end
    endtask

    initial begin
        bool_dummy: begin end
        for (int i = 0; i < N_REQ; i++) begin
            info_of[i] = INFO_W'(12'h265 + 16 * i);
        end
        for (int i = 0; i < 10; i++) begin
            vecs[i] = mk(9'h1FF, (i % 4) + 1, 0, 0, ROUTE_W'(32'h0100_0000 + i * 32'h0011_1111), i % 9, 0, (i % 4) + 3);
        end
        vecs[10] = mk(9'h010, 3,  0, 0, 30'h1234567,  4, 0, 5);
        vecs[11] = mk(9'h080, 1,  0, 0, 30'h0ABCDEF,  7, 0, 3);
        vecs[12] = mk(9'h101, 2,  0, 0, 30'h3000008,  8, 0, 4);
        vecs[13] = mk(9'h101, 2,  0, 0, 30'h0000100,  0, 0, 4);
        vecs[14] = mk(9'h004, 0,  0, 0, 30'h3FFFFFF,  2, 1, TIMEOUT + 2);
        vecs[15] = mk(9'h004, 2,  0, 0, 30'h2222222,  2, 0, 5);
        vecs[16] = mk(9'h020, 1,  0, 0, 30'h0555555,  5, 0, 3);
        vecs[17] = mk(9'h002, 1,  4, 0, 30'h1111111,  1, 0, 7);
        vecs[18] = mk(9'h040, TIMEOUT, 0, 0, 30'h2468ACE, 6, 0, TIMEOUT + 2);
        vecs[19] = mk(9'h100, 2,  0, 1, 30'h1357913,  8, 0, 4);
        vecs[20] = mk(9'h1FF, 1,  0, 0, 30'h0C0FFEE,  0, 0, 3);

        reset     = 1'b0;
        req_valid = '0;
        eng_ready = 1'b1;
        eng_done  = 1'b0;
        eng_route = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_info[i*INFO_W +: INFO_W] = info_of[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_eng_req", eng_req, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_outputs", {resp_onehot, resp_id, resp_route, resp_err, eng_sor_des}, '0);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_vec(i, vecs[i]);
        end

        // reset while waiting on the engine, then a stray eng_done in IDLE
        begin
            int c;
            int bad;
            @(negedge clk);
            req_valid = 9'h008;
            eng_ready = 1'b1;
            c = 0;
            while (!eng_req && c < 10) begin
                @(negedge clk);
                c++;
            end
            chk("rw_eng_req_seen", eng_req, 1);
            @(negedge clk);
            chk("rw_busy_wait", busy, 1);
            reset = 1'b0;
            req_valid = '0;
            #1;
            chk("rw_busy_async", busy, 0);
            chk("rw_eng_req_async", eng_req, 0);
            chk("rw_resp_valid_async", resp_valid, 0);
            chk("rw_sor_des_async", eng_sor_des, 0);
            chk("rw_resp_route_async", resp_route, 0);
            @(negedge clk);
            reset     = 1'b1;
            eng_done  = 1'b1;
            eng_route = 30'h2AAAAAAA;
            @(negedge clk);
            eng_done = 1'b0;
            bad = 0;
            for (int j = 0; j < 6; j++) begin
                if (resp_valid || busy || eng_req) bad++;
                @(negedge clk);
            end
            chk("rw_late_done_ignored", bad, 0);
            chk("rw_route_unchanged", resp_route, 0);
        end

        run_vec(20, vecs[20]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
